// File: rtl/chunked_adder_sequencer_pkg.sv
// rtl/chunked_adder_sequencer_pkg.sv - shared types and sizing helpers for the chunked adder sequencer
package chunked_adder_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ID_W = 1;

  // Chunk counter width; a single-chunk adder still needs one counter bit.
  function automatic int count_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_sequencer_chunk_adder.sv
// rtl/chunked_adder_sequencer_chunk_adder.sv - combinational CHUNK-bit ripple adder slice
module chunk_adder
  import chunked_adder_sequencer_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  // Each bit is two half adders; their carries can never both be set, so OR merges them.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic w_p;
    logic w_g;
    logic w_h;
    assign w_p        = i_a[i] ^ i_b[i];
    assign w_g        = i_a[i] & i_b[i];
    assign o_sum[i]   = w_p ^ w_c[i];
    assign w_h        = w_p & w_c[i];
    assign w_c[i+1]   = w_g | w_h;
  end

  assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/chunked_adder_sequencer.sv
// rtl/chunked_adder_sequencer.sv - two-requester round-robin WIDTH-bit adder built on one shared CHUNK-bit slice
module chunked_adder_sequencer
  import chunked_adder_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH:0]   resp_sum,
  output logic             resp_id
);

  localparam int K  = WIDTH / CHUNK;
  localparam int CW = count_width(K);
  localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;
  logic [CW-1:0]     r_count;
  logic [ID_W-1:0]   r_owner;
  logic [ID_W-1:0]   r_last_grant;
  logic              r_resp_valid;
  logic [WIDTH:0]    r_resp_sum;
  logic [ID_W-1:0]   r_resp_id;

  logic [CHUNK-1:0]       w_s;
  logic                   w_cout;
  logic [WIDTH+CHUNK-1:0] w_sum_wide;
  logic [WIDTH-1:0]       w_sum_next;
  logic                   w_grant;
  logic                   w_accept;

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .i_a   (r_a[CHUNK-1:0]),
    .i_b   (r_b[CHUNK-1:0]),
    .i_cin (r_carry),
    .o_sum (w_s),
    .o_cout(w_cout)
  );

  // New slice enters at the top; after K steps chunk 0 has drifted down to the LSBs.
  assign w_sum_wide = {w_s, r_sum};
  assign w_sum_next = w_sum_wide[WIDTH+CHUNK-1:CHUNK];

  assign w_grant    = (req0_valid && req1_valid) ? ~r_last_grant[0] : req1_valid;
  assign req0_ready = (r_state == IDLE) && req0_valid && !w_grant;
  assign req1_ready = (r_state == IDLE) && req1_valid && w_grant;
  assign w_accept   = req0_ready || req1_ready;

  assign resp_valid = r_resp_valid;
  assign resp_sum   = r_resp_sum;
  assign resp_id    = r_resp_id[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_carry      <= 1'b0;
      r_count      <= '0;
      r_owner      <= '0;
      r_last_grant <= '1;
      r_resp_valid <= 1'b0;
      r_resp_sum   <= '0;
      r_resp_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant ? req1_a : req0_a;
            r_b          <= w_grant ? req1_b : req0_b;
            r_carry      <= 1'b0;
            r_count      <= '0;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= ADD;
          end
        end
        ADD: begin
          r_carry <= w_cout;
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= w_sum_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_CNT) begin
            r_state      <= DONE;
            r_resp_sum   <= {w_cout, w_sum_next};
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_owner;
          end
        end
        DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/chunked_adder_sequencer.md
Name: chunked_adder_sequencer

Overview:
- Shares one narrow CHUNK-bit ripple adder between two requesters.
- Sequences WIDTH-bit additions over it, one chunk per cycle, with a registered carry.
- Sits between operand producers (valid/ready) and a single result consumer (valid/ready).
- Round-robin arbitration; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits. Must be a positive multiple of CHUNK.
- CHUNK, 2, adder slice width in bits.
- K (derived, localparam), WIDTH/CHUNK, number of ADD cycles.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_sum  out  WIDTH+1  a+b; MSB is the carry-out.
- resp_id  out  1  index of the requester that owns resp_sum.

Behaviour:
- Reset values: state=IDLE, resp_valid=0, resp_sum=0, resp_id=0, carry=0, count=0, last_grant=1 (requester 0 wins the first tie).
- States: IDLE, ADD, DONE.
- IDLE grant:
  - One requester valid: it is granted.
  - Both valid: grant the one != last_grant.
  - reqN_ready = (state==IDLE) && (grant==N). Combinational from valid and state, never from resp_ready.
- IDLE accept (valid&&ready):
  - Capture a and b into shift registers; carry=0; count=0; owner id latched; last_grant=id.
  - Next state ADD.
- ADD, each cycle:
  - Sub-adder computes {cout, s} = a[CHUNK-1:0] + b[CHUNK-1:0] + carry.
  - carry<=cout.
  - a and b shift right by CHUNK.
  - s is shifted into the sum register from the top, so after K cycles chunk 0 sits at the LSBs.
  - count increments.
  - When count==K-1: next state DONE; resp_sum <= {cout, sum}; resp_valid<=1; resp_id<=owner.
- Latency: accept at cycle T -> resp_valid=1 at cycle T+K+1.
- DONE:
  - resp_valid, resp_sum and resp_id are held stable until resp_valid&&resp_ready.
  - Both reqN_ready are 0.
  - On handshake: resp_valid<=0, next state IDLE.
  - A new request may be accepted in that IDLE cycle. Peak throughput is one op per K+2 cycles.
- Arithmetic: unsigned; full carry chain; no overflow loss (WIDTH+1-bit result).
- Boundaries:
  - Operands of all ones produce carry-out 1 at resp_sum[WIDTH].
  - CHUNK==WIDTH gives K=1: exactly one ADD cycle.
  - Only one requester active: granted every time, with no forced idle for fairness.
  - A requester dropping valid in IDLE before grant is legal; nothing is captured.
- rst in any state overrides everything: the next cycle is in reset values, the in-flight op is discarded, and no response is produced for it.
- Inputs are sampled only at accept; operand changes during ADD or DONE have no effect.

Decomposition:
- Shared package:
  - state enum {IDLE, ADD, DONE}.
  - Count width constant: clog2(K), minimum 1.
  - Requester-id width constant: 1.
- Sub-module chunk_adder:
  - Combinational, CHUNK-bit a, b, cin -> CHUNK-bit sum, cout.
  - Ripple of half-adders with OR-merged carries.
  - Instantiated once.

Test Plan (WIDTH=8, CHUNK=2, K=4):
- req0 a=0x0F b=0x01 accepted at cycle 0, resp_ready=1 -> resp_valid=1 at cycle 5, resp_sum=0x010, resp_id=0; req0_ready=0 during cycles 1-5.
- After reset, both valid: req0 a=0xFF b=0x01, req1 a=0x80 b=0x80 -> first response sum=0x100 id=0; req1 accepted in the following IDLE; second response sum=0x100 id=1.
- resp_ready=0 for 3 cycles in DONE with result 0x1FE (a=b=0xFF) -> resp_valid/resp_sum/resp_id stable; req ready both 0; on handshake, IDLE next cycle.
- rst asserted during the 2nd ADD cycle -> next cycle resp_valid=0 and state IDLE; no response for that op; a fresh request is then accepted normally.
- req1 only, back-to-back ops (0x01+0x02, 0x10+0x20) -> accepted at cycles 0 and 6; results 0x003 and 0x030, both id=1.
- Random/exhaustive: all 65536 a,b pairs alternating requesters with random resp_ready stalls -> every resp_sum==a+b; ids alternate whenever both are valid.
